fetch_stage: RTL and testbench

Fetch stage of the pipelined MIPS core. It owns the program counter and drives a ready-handshaked instruction-memory port. It holds a one-entry skid buffer for decode stalls and delivers `instruction_D`, `pc_plus_four_D` and `valid_D` to the decode stage. It consumes decode's `pc_src`/`jump_address` redirect; there is no branch delay slot, so every instruction fetched after a taken branch or jump is discarded.

---
 rtl/fetch_defs.sv | 6 +
 rtl/fetch_skid_buffer.sv | 24 ++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fetch_defs.sv
// fetch_defs: shared state encodings and constants for the fetch stage
package fetch_defs;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DROP} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {instr, pc4} register with load/clear/full
module fetch_skid_buffer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        full
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      instr <= '0;
      pc4 <= '0;
      full <= 1'b0;
    end else if (clear) full <= 1'b0;
    else if (load) begin
      instr <= instr_in;
      pc4 <= pc4_in;
      full <= 1'b1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, ready-handshaked imem port, skid buffer and decode register
module fetch_stage
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_D,
  input  logic        pc_src,
  input  logic [31:0] jump_address,
  output logic [31:0] pc_F,
  output logic [31:0] instruction_D,
  output logic [31:0] pc_plus_four_D,
  output logic        valid_D
);
  state_t state, state_n;
  logic [31:0] pc, pc_n, target, target_n, instr_n, pc4_n, buf_instr, buf_pc4;
  logic valid_n, bubble, buf_load, buf_clear, buf_full;
  wire fire = imem_req & imem_ready;
  wire redirect = pc_src & valid_D & ~stall_D;
  wire [31:0] pc4 = pc + 32'd4;
  assign imem_req = state == RUN || state == DROP;
  assign imem_addr = pc;
  assign pc_F = pc;
  fetch_skid_buffer u_skid (
    .clock(clock), .reset_n(reset_n), .load(buf_load), .clear(buf_clear),
    .instr_in(imem_rdata), .pc4_in(pc4), .instr(buf_instr), .pc4(buf_pc4), .full(buf_full)
  );
  always_comb begin
    state_n = state;
    pc_n = pc;
    target_n = target;
    instr_n = instruction_D;
    pc4_n = pc_plus_four_D;
    valid_n = valid_D;
    bubble = 1'b0;
    buf_load = 1'b0;
    buf_clear = 1'b0;
    case (state)
      IDLE: state_n = RUN;
      RUN:
        if (redirect) begin
          bubble = 1'b1;
          if (fire) pc_n = jump_address;
          else begin
            target_n = jump_address;
            state_n = DROP;
          end
        end else if (fire) begin
          pc_n = pc4;
          if (stall_D) begin
            buf_load = 1'b1;
            state_n = HOLD;
          end else begin
            instr_n = imem_rdata;
            pc4_n = pc4;
            valid_n = 1'b1;
          end
        end else bubble = ~stall_D;
      HOLD:
        if (!stall_D) begin
          buf_clear = 1'b1;
          state_n = RUN;
          if (redirect) begin
            bubble = 1'b1;
            pc_n = jump_address;
          end else begin
            instr_n = buf_instr;
            pc4_n = buf_pc4;
            valid_n = buf_full;
          end
        end
      DROP: begin
        bubble = ~stall_D;
        if (fire) begin
          pc_n = target;
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
    instr_n = bubble ? NOP_INSTR : instr_n;
    pc4_n = bubble ? 32'h0 : pc4_n;
    valid_n = bubble ? 1'b0 : valid_n;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      target <= '0;
      instruction_D <= NOP_INSTR;
      pc_plus_four_D <= '0;
      valid_D <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      target <= target_n;
      instruction_D <= instr_n;
      pc_plus_four_D <= pc4_n;
      valid_D <= valid_n;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a queue-based model
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0040_0000;
  logic clock = 1'b0, reset_n = 1'b0;
  logic imem_req, imem_ready = 1'b0, stall_D = 1'b0, pc_src = 1'b0, valid_D;
  logic [31:0] imem_addr, imem_rdata, jump_address = '0, pc_F, instruction_D, pc_plus_four_D;
  int n_checks = 0, n_err = 0;
  always #5 clock = ~clock;
  assign imem_rdata = imem_addr + 32'd1;
  fetch_stage #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall_D(stall_D), .pc_src(pc_src),
    .jump_address(jump_address), .pc_F(pc_F), .instruction_D(instruction_D),
    .pc_plus_four_D(pc_plus_four_D), .valid_D(valid_D)
  );
  bit m_started;
  logic [31:0] m_pc, m_i, m_p4;
  bit m_v;
  logic [63:0] m_skid[$];
  logic [31:0] m_pend[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit m_req();
    return m_started && m_skid.size() == 0;
  endfunction
  task automatic m_reset();
    m_started = 0;
    m_pc = RPC;
    m_i = 0;
    m_p4 = 0;
    m_v = 0;
    m_skid.delete();
    m_pend.delete();
  endtask
  task automatic m_bubble();
    m_i = 0;
    m_p4 = 0;
    m_v = 0;
  endtask
  task automatic m_step(input bit r, input bit s, input bit p, input logic [31:0] j);
    bit fire, redir;
    logic [63:0] w;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    fire = m_req() && r;
    redir = p && m_v && !s;
    if (m_skid.size() != 0) begin
      if (!s) begin
        w = m_skid.pop_front();
        if (redir) begin
          m_bubble();
          m_pc = j;
        end else begin
          m_i = w[63:32];
          m_p4 = w[31:0];
          m_v = 1;
        end
      end
    end else if (m_pend.size() != 0) begin
      if (!s) m_bubble();
      if (fire) m_pc = m_pend.pop_front();
    end else if (redir) begin
      m_bubble();
      if (fire) m_pc = j;
      else m_pend.push_back(j);
    end else if (fire) begin
      w = {m_pc + 32'd1, m_pc + 32'd4};
      m_pc += 32'd4;
      if (s) m_skid.push_back(w);
      else begin
        m_i = w[63:32];
        m_p4 = w[31:0];
        m_v = 1;
      end
    end else if (!s) m_bubble();
  endtask
  task automatic compare();
    check("imem_req", imem_req, m_req());
    check("imem_addr", imem_addr, m_pc);
    check("pc_F", pc_F, m_pc);
    check("instruction_D", instruction_D, m_i);
    check("pc_plus_four_D", pc_plus_four_D, m_p4);
    check("valid_D", valid_D, m_v);
  endtask
  task automatic cyc(input bit r, input bit s, input bit p, input logic [31:0] j);
    imem_ready = r;
    stall_D = s;
    pc_src = p;
    jump_address = j;
    @(posedge clock);
    m_step(r, s, p, j);
    @(negedge clock);
    compare();
  endtask
  initial begin
    m_reset();
    repeat (2) @(negedge clock);
    compare();
    reset_n = 1'b1;
    check("first_req", imem_req, 1'b0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("d0_instr", instruction_D, 32'h0040_0001);
    check("d0_pc4", pc_plus_four_D, 32'h0040_0004);
    cyc(1, 0, 0, 0);
    check("d1_instr", instruction_D, 32'h0040_0005);
    check("d1_pc4", pc_plus_four_D, 32'h0040_0008);
    check("d1_valid", valid_D, 1'b1);
    cyc(1, 1, 0, 0);
    check("hold_req", imem_req, 1'b0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("skid_instr", instruction_D, 32'h0040_0009);
    cyc(1, 0, 0, 0);
    check("after_skid", instruction_D, 32'h0040_000d);
    cyc(1, 0, 1, 32'h0040_0100);
    check("redir_bubble", valid_D, 1'b0);
    check("redir_addr", imem_addr, 32'h0040_0100);
    cyc(1, 0, 0, 0);
    check("redir_pc4", pc_plus_four_D, 32'h0040_0104);
    check("redir_valid", valid_D, 1'b1);
    cyc(0, 0, 1, 32'h0040_0200);
    cyc(0, 0, 0, 0);
    check("drop_addr", imem_addr, 32'h0040_0104);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("drop_target", imem_addr, 32'h0040_0200);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 32'h0040_0800);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 32'h0040_0900);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 32'hFFFF_FFF8);
    repeat (4) cyc(1, 0, 0, 0);
    check("wrap_pc", pc_F, 32'h0000_0008);
    cyc(1, 1, 0, 0);
    reset_n = 1'b0;
    #1;
    m_reset();
    compare();
    @(negedge clock);
    reset_n = 1'b1;
    compare();
    repeat (3) cyc(1, 0, 0, 0);
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
